// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and counter sizing.
package ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2,
      GAP   = 2'd3
   } state_t;

   // Bits needed to hold values 0..v-1, never less than 1.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/ser_down_counter.sv
// Loadable down-counter that saturates at zero and flags it.
module ser_down_counter #(
   parameter int W = 4
) (
   input  logic         gclk,
   input  logic         grst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial feeder with valid/ready input and optional idle gap.
// Defining SER_PARITY_EN appends an even-parity bit after every word.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit IDLE_BIT   = 1'b0,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             frame_start,
   output logic             busy
);
   localparam int            CW      = clog2(WIDTH);
   localparam int            GW      = 4;
   localparam bit            HAS_GAP = (GAP_CYCLES > 0);
   localparam logic [CW-1:0] BIT_LD  = CW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LD  = GW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic             bit_zero;
   logic             gap_zero;
   logic             word_done;
   logic             accept;

`ifdef SER_PARITY_EN
   logic par_r;
   assign word_done = (state == PAR);
`else
   assign word_done = (state == SHIFT) && bit_zero;
`endif

   // Ready in IDLE and in whichever cycle closes the word, so streams run bubble-free.
   assign in_ready = reset && ((state == IDLE) ||
                               (word_done && !HAS_GAP) ||
                               ((state == GAP) && gap_zero));
   assign accept   = in_valid && in_ready;

   ser_down_counter #(.W(CW)) u_bit_cnt (
      .gclk     (clk),
      .grst_n   (reset),
      .load     (accept),
      .load_val (BIT_LD),
      .dec      ((state == SHIFT) && !bit_zero),
      .zero     (bit_zero)
   );

   ser_down_counter #(.W(GW)) u_gap_cnt (
      .gclk     (clk),
      .grst_n   (reset),
      .load     (word_done && HAS_GAP),
      .load_val (GAP_LD),
      .dec      ((state == GAP) && !gap_zero),
      .zero     (gap_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         sreg        <= '0;
         dout        <= IDLE_BIT;
         dout_valid  <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
`ifdef SER_PARITY_EN
         par_r       <= 1'b0;
`endif
      end else begin
         frame_start <= 1'b0;
         if (accept) begin
            // First bit goes straight to dout; sreg keeps the rest left-aligned.
            state       <= SHIFT;
            sreg        <= in_data << 1;
            dout        <= in_data[WIDTH-1];
            dout_valid  <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
`ifdef SER_PARITY_EN
            par_r       <= ^in_data;
`endif
         end else begin
            case (state)
               IDLE: begin
                  dout       <= IDLE_BIT;
                  dout_valid <= 1'b0;
                  busy       <= 1'b0;
               end
               SHIFT: begin
                  if (!bit_zero) begin
                     dout <= sreg[WIDTH-1];
                     sreg <= sreg << 1;
                  end else begin
`ifdef SER_PARITY_EN
                     state      <= PAR;
                     dout       <= par_r;
                     dout_valid <= 1'b1;
`else
                     state      <= HAS_GAP ? GAP : IDLE;
                     busy       <= HAS_GAP;
                     dout       <= IDLE_BIT;
                     dout_valid <= 1'b0;
`endif
                  end
               end
`ifdef SER_PARITY_EN
               PAR: begin
                  state      <= HAS_GAP ? GAP : IDLE;
                  busy       <= HAS_GAP;
                  dout       <= IDLE_BIT;
                  dout_valid <= 1'b0;
               end
`endif
               GAP: begin
                  if (gap_zero) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  dout       <= IDLE_BIT;
                  dout_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: two instances (no gap / 2-cycle gap, idle-high)
// compared cycle by cycle against an expected output stream built from the word list.
module tb_bit_serializer;
   localparam int W  = 8;
   localparam int G1 = 2;
`ifdef SER_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] dat  [2];
   logic         v    [2];
   logic         rdy  [2];
   logic         dout [2];
   logic         dv   [2];
   logic         fs   [2];
   logic         busy [2];

   int checks = 0;
   int errs   = 0;
   logic [W-1:0] wq[$];

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) d0 (
      .clk(clk), .reset(reset), .in_data(dat[0]), .in_valid(v[0]), .in_ready(rdy[0]),
      .dout(dout[0]), .dout_valid(dv[0]), .frame_start(fs[0]), .busy(busy[0]));

   bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1), .GAP_CYCLES(G1)) d1 (
      .clk(clk), .reset(reset), .in_data(dat[1]), .in_valid(v[1]), .in_ready(rdy[1]),
      .dout(dout[1]), .dout_valid(dv[1]), .frame_start(fs[1]), .busy(busy[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] snap(input int s);
      return {rdy[s], busy[s], fs[s], dv[s], dout[s]};
   endfunction

   // Expected per-cycle {ready,busy,frame_start,valid,dout} with in_valid offered continuously.
   task automatic model(input int s, input logic [W-1:0] ws[$], output logic [4:0] q[$]);
      logic       ib;
      int         span;
      logic       r;
      logic [4:0] e;
      logic [4:0] idle;
      ib   = (s == 1);
      span = W + P + ((s == 1) ? G1 : 0);
      idle = {4'b1000, ib};
      q.delete();
      q.push_back(idle);
      foreach (ws[i]) begin
         for (int k = 0; k < span; k++) begin
            r = (k == span - 1);
            if (k < W)          e = {r, 1'b1, (k == 0), 1'b1, ws[i][W-1-k]};
            else if (k < W + P) e = {r, 1'b1, 1'b0, 1'b1, 1'($countones(ws[i]) % 2)};
            else                e = {r, 1'b1, 1'b0, 1'b0, ib};
            q.push_back(e);
         end
      end
      repeat (2) q.push_back(idle);
   endtask

   // Offer words back-to-back; with drop, pull in_valid low (and scramble data) for 3
   // cycles after the first accept, then re-offer the next word.
   task automatic stream(input int s, input logic [W-1:0] ws[$], input bit drop, input string tag);
      logic [4:0] expq[$];
      int         idx;
      int         hold;
      bit         acc;
      idx  = 0;
      hold = 0;
      model(s, ws, expq);
      v[s]   = 1'b1;
      dat[s] = ws[0];
      for (int c = 0; c < expq.size(); c++) begin
         chk($sformatf("%s[%0d]", tag, c), 32'(snap(s)), 32'(expq[c]));
         acc = v[s] & rdy[s];
         tick;
         if (hold > 0) begin
            hold--;
            if (hold == 0) begin
               v[s]   = 1'b1;
               dat[s] = ws[idx];
            end
         end
         if (acc) begin
            idx++;
            if (drop && idx == 1 && idx < ws.size()) begin
               v[s]   = 1'b0;
               dat[s] = W'($urandom);
               hold   = 3;
            end else if (idx < ws.size()) dat[s] = ws[idx];
            else v[s] = 1'b0;
         end
      end
      v[s] = 1'b0;
   endtask

   task automatic sparse;
      logic [W-1:0] ws[$];
      bit           got[$];
      bit           expb[$];
      int           fsn, idx, wait_c;
      bit           acc;
      fsn = 0;
      idx = 0;
      for (int i = 0; i < 6; i++) ws.push_back(W'($urandom));
      foreach (ws[i]) begin
         for (int k = W - 1; k >= 0; k--) expb.push_back(ws[i][k]);
         if (P == 1) expb.push_back(($countones(ws[i]) % 2) == 1);
      end
      wait_c = $urandom_range(0, 3);
      for (int c = 0; c < 300; c++) begin
         if (dv[0]) got.push_back(dout[0]);
         if (fs[0]) fsn++;
         acc = v[0] & rdy[0];
         tick;
         if (acc) begin
            idx++;
            v[0]   = 1'b0;
            wait_c = $urandom_range(0, 3);
         end
         if (!v[0] && idx < ws.size()) begin
            if (wait_c == 0) begin
               v[0]   = 1'b1;
               dat[0] = ws[idx];
            end else wait_c--;
         end
      end
      chk("sparse_len", got.size(), expb.size());
      chk("sparse_fs", fsn, ws.size());
      for (int i = 0; i < expb.size() && i < got.size(); i++)
         chk($sformatf("sparse_bit[%0d]", i), 32'(got[i]), 32'(expb[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < 2; s++) begin
         v[s]   = 1'b0;
         dat[s] = '0;
      end
      repeat (2) tick;
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("rst_dout%0d", s), 32'(dout[s]), 32'(s == 1));
         chk($sformatf("rst_dv%0d", s), 32'(dv[s]), 0);
         chk($sformatf("rst_fs%0d", s), 32'(fs[s]), 0);
         chk($sformatf("rst_busy%0d", s), 32'(busy[s]), 0);
         chk($sformatf("rst_rdy%0d", s), 32'(rdy[s]), 0);
      end
      @(negedge clk);
      reset = 1'b1;
      tick;

      wq.delete(); wq.push_back(8'h77);
      stream(0, wq, 1'b0, "t1_77");
      wq.delete(); wq.push_back(8'hF0); wq.push_back(8'h0F);
      stream(0, wq, 1'b0, "t2_f00f");
      wq.delete(); wq.push_back(8'hB1); wq.push_back(8'h07);
      stream(0, wq, 1'b0, "t5_par0");
      stream(1, wq, 1'b0, "t5_par1");
      wq.delete(); repeat (2) wq.push_back(W'($urandom));
      stream(1, wq, 1'b0, "t3_gap");
      wq.delete(); repeat (5) wq.push_back(W'($urandom));
      stream(0, wq, 1'b0, "rnd0");
      stream(1, wq, 1'b0, "rnd1");
      wq.delete(); wq.push_back(8'hC3); wq.push_back(8'h5A);
      stream(0, wq, 1'b1, "t6_drop0");
      stream(1, wq, 1'b1, "t6_drop1");

      // Reset on the 4th bit of 8'hAA (bit 4 = 0), then a clean 8'h81 frame.
      v[0] = 1'b1; dat[0] = 8'hAA;
      tick;
      v[0] = 1'b0;
      repeat (3) tick;
      chk("t4_pre_dv", 32'(dv[0]), 1);
      chk("t4_pre_busy", 32'(busy[0]), 1);
      #2 reset = 1'b0;
      #1;
      chk("t4_rst_dout", 32'(dout[0]), 0);
      chk("t4_rst_dv", 32'(dv[0]), 0);
      chk("t4_rst_busy", 32'(busy[0]), 0);
      chk("t4_rst_rdy", 32'(rdy[0]), 0);
      @(negedge clk);
      reset = 1'b1;
      tick;
      wq.delete(); wq.push_back(8'h81);
      stream(0, wq, 1'b0, "t4_81");

      sparse();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
